// File: rtl/ov5640_pkg.sv
// Shared OV5640 capture types: FSM state, pixel/phase width helpers, default crop window.
package ov5640_pkg;

   typedef enum logic [1:0] {
      ST_SKIP    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_ACTIVE  = 2'd2
   } cap_state_t;

   localparam int SENSOR_W          = 1024;
   localparam int SENSOR_H          = 768;
   localparam int DEF_DATA_W        = 8;
   localparam int DEF_BYTES_PER_PIX = 2;

   typedef struct packed {
      logic [11:0] h_start;
      logic [11:0] h_stop;
      logic [11:0] v_start;
      logic [11:0] v_stop;
   } win_cfg_t;

   function automatic int pix_w(input int data_w, input int bytes_per_pix);
      return data_w * bytes_per_pix;
   endfunction

   function automatic int phase_w(input int bytes_per_pix);
      return (bytes_per_pix > 1) ? $clog2(bytes_per_pix) : 1;
   endfunction

   // Window the SCCB block programs at boot: 800x480 centred-ish on the sensor.
   function automatic win_cfg_t default_window();
      win_cfg_t w;
      w.h_start = 12'd200;
      w.h_stop  = 12'(SENSOR_W - 24);
      w.v_start = 12'd200;
      w.v_stop  = 12'(SENSOR_H - 88);
      return w;
   endfunction

endpackage

// File: rtl/ov5640_byte_pack.sv
// Byte phase tracking and pixel assembly; pix_data_o/pix_done_o are combinational with the last byte.
// No backpressure: the sensor cannot be stalled.
module ov5640_byte_pack
   import ov5640_pkg::*;
#(
   parameter  int DATA_W        = DEF_DATA_W,
   parameter  int BYTES_PER_PIX = DEF_BYTES_PER_PIX,
   localparam int PIX_W         = pix_w(DATA_W, BYTES_PER_PIX),
   localparam int PH_W          = phase_w(BYTES_PER_PIX)
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              href_i,
   input  logic              href_rise_i,
   input  logic              byte_swap_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [PIX_W-1:0]  pix_data_o,
   output logic              pix_done_o,
   output logic              partial_o
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(BYTES_PER_PIX - 1);

   logic [PH_W-1:0]  phase_q, phase_d, phase_cur, lane;
   logic [PIX_W-1:0] acc_q, acc_d, word;

   always_comb begin
      phase_cur = href_rise_i ? '0 : phase_q;
      lane      = byte_swap_i ? phase_cur : PH_LAST - phase_cur;
      word      = acc_q;
      word[lane*DATA_W +: DATA_W] = data_i;
      phase_d   = phase_q;
      acc_d     = acc_q;
      if (href_i) begin
         phase_d = (phase_cur == PH_LAST) ? '0 : phase_cur + 1'b1;
         acc_d   = word;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q <= '0;
         acc_q   <= '0;
      end else begin
         phase_q <= phase_d;
         acc_q   <= acc_d;
      end
   end

   assign pix_data_o = word;
   assign pix_done_o = href_i && (phase_cur == PH_LAST);
   assign partial_o  = (phase_q != '0);

endmodule

// File: rtl/ov5640_crop_capture.sv
// DVP capture with frame skip and frame-atomic crop window; outputs registered, 1 cycle after the last byte.
// No backpressure: pix_vld_o is a strobe the frame-buffer writer must always accept.
module ov5640_crop_capture
   import ov5640_pkg::*;
#(
   parameter  int DATA_W        = DEF_DATA_W,
   parameter  int BYTES_PER_PIX = DEF_BYTES_PER_PIX,
   parameter  int CNT_W         = 12,
   parameter  int SKIP_FRAMES   = 10,
   localparam int PIX_W         = pix_w(DATA_W, BYTES_PER_PIX)
)(
   input  logic              ov5640_pclk_i,
   input  logic              s_rst_i,
   input  logic              ov5640_href_i,
   input  logic              ov5640_vsync_i,
   input  logic [DATA_W-1:0] ov5640_data_i,
   input  logic [CNT_W-1:0]  cfg_h_start_i,
   input  logic [CNT_W-1:0]  cfg_h_stop_i,
   input  logic [CNT_W-1:0]  cfg_v_start_i,
   input  logic [CNT_W-1:0]  cfg_v_stop_i,
   input  logic              cfg_byte_swap_i,
   output logic              pix_vld_o,
   output logic [PIX_W-1:0]  pix_data_o,
   output logic [CNT_W-1:0]  pix_x_o,
   output logic [CNT_W-1:0]  pix_y_o,
   output logic              pix_sof_o,
   output logic              pix_eol_o,
   output logic              frame_done_o,
   output logic              line_err_o
);

   localparam int              SK_W      = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
   localparam logic [SK_W-1:0] SKIP_LAST = SK_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

   cap_state_t       state_q, state_d;
   logic             latch_cfg, active;
   logic [SK_W-1:0]  skip_q, skip_d;
   logic             vsync_d1_q, href_d1_q, vs_rise, href_rise, href_fall;
   logic [CNT_W-1:0] h_start_q, h_stop_q, v_start_q, v_stop_q;
   logic             swap_q;
   logic [CNT_W-1:0] col_q, col_d, col_cur, line_q, line_d;
   logic             drop_q, drop_d, line_err_q, line_err_d;
   logic             in_h, in_v, emit;
   logic [PIX_W-1:0] pk_data;
   logic             pk_done, pk_partial;
   logic             vld_d, sof_d, eol_d, fdone_d;
   logic [PIX_W-1:0] data_d;
   logic [CNT_W-1:0] x_d, y_d;

   assign vs_rise   = ov5640_vsync_i & ~vsync_d1_q;
   assign href_rise = ov5640_href_i & ~href_d1_q;
   assign href_fall = ~ov5640_href_i & href_d1_q;

   ov5640_byte_pack #(.DATA_W(DATA_W), .BYTES_PER_PIX(BYTES_PER_PIX)) u_pack (
      .clk_i       (ov5640_pclk_i),
      .rst_i       (s_rst_i),
      .href_i      (ov5640_href_i),
      .href_rise_i (href_rise),
      .byte_swap_i (swap_q),
      .data_i      (ov5640_data_i),
      .pix_data_o  (pk_data),
      .pix_done_o  (pk_done),
      .partial_o   (pk_partial)
   );

   always_ff @(posedge ov5640_pclk_i) begin
      if (s_rst_i) state_q <= ST_SKIP;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SKIP:    if (SKIP_FRAMES == 0 || (vs_rise && skip_q == SKIP_LAST)) state_d = ST_WAIT_VS;
         ST_WAIT_VS: if (vs_rise) state_d = ST_ACTIVE;
         ST_ACTIVE:  state_d = ST_ACTIVE;
         default:    state_d = ST_SKIP;
      endcase
   end

   always_comb begin
      latch_cfg = (state_q != ST_SKIP) && vs_rise;
      active    = (state_q == ST_ACTIVE);
   end

   always_comb begin
      skip_d  = (state_q == ST_SKIP && vs_rise) ? skip_q + 1'b1 : skip_q;
      col_cur = href_rise ? '0 : col_q;
      in_h    = (col_cur >= h_start_q) && (col_cur < h_stop_q);
      in_v    = (line_q >= v_start_q) && (line_q < v_stop_q);
      // A line cut by vsync stays dropped until the next href rise.
      emit    = active && !vs_rise && !(drop_q && !href_rise) && pk_done && in_h && in_v;

      col_d = col_cur;
      if (vs_rise)                      col_d = '0;
      else if (pk_done && col_cur != '1) col_d = col_cur + 1'b1;

      line_d = line_q;
      if (vs_rise)                                     line_d = '0;
      else if (href_fall && !drop_q && line_q != '1)   line_d = line_q + 1'b1;

      drop_d = drop_q;
      if (vs_rise && ov5640_href_i) drop_d = 1'b1;
      else if (href_rise)           drop_d = 1'b0;

      line_err_d = line_err_q;
      if (latch_cfg)
         line_err_d = 1'b0;
      else if (active && href_fall && !drop_q &&
               (pk_partial || (in_v && h_start_q < h_stop_q && col_q < h_stop_q)))
         line_err_d = 1'b1;

      vld_d   = emit;
      sof_d   = emit && (col_cur == h_start_q) && (line_q == v_start_q);
      eol_d   = emit && (col_cur == h_stop_q - 1'b1);
      fdone_d = active && vs_rise;
      data_d  = emit ? pk_data : pix_data_o;
      x_d     = emit ? col_cur - h_start_q : pix_x_o;
      y_d     = emit ? line_q - v_start_q : pix_y_o;
   end

   always_ff @(posedge ov5640_pclk_i) begin
      if (s_rst_i) begin
         skip_q       <= '0;
         vsync_d1_q   <= 1'b0;
         href_d1_q    <= 1'b0;
         h_start_q    <= '0;
         h_stop_q     <= '0;
         v_start_q    <= '0;
         v_stop_q     <= '0;
         swap_q       <= 1'b0;
         col_q        <= '0;
         line_q       <= '0;
         drop_q       <= 1'b0;
         line_err_q   <= 1'b0;
         pix_vld_o    <= 1'b0;
         pix_data_o   <= '0;
         pix_x_o      <= '0;
         pix_y_o      <= '0;
         pix_sof_o    <= 1'b0;
         pix_eol_o    <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         skip_q       <= skip_d;
         vsync_d1_q   <= ov5640_vsync_i;
         href_d1_q    <= ov5640_href_i;
         if (latch_cfg) begin
            h_start_q <= cfg_h_start_i;
            h_stop_q  <= cfg_h_stop_i;
            v_start_q <= cfg_v_start_i;
            v_stop_q  <= cfg_v_stop_i;
            swap_q    <= cfg_byte_swap_i;
         end
         col_q        <= col_d;
         line_q       <= line_d;
         drop_q       <= drop_d;
         line_err_q   <= line_err_d;
         pix_vld_o    <= vld_d;
         pix_data_o   <= data_d;
         pix_x_o      <= x_d;
         pix_y_o      <= y_d;
         pix_sof_o    <= sof_d;
         pix_eol_o    <= eol_d;
         frame_done_o <= fdone_d;
      end
   end

   assign line_err_o = line_err_q;

endmodule

// File: tb/tb_ov5640_crop_capture.sv
// Directed bench for ov5640_crop_capture: 8x4-pixel frames, byte value = line*16 + byte index.
module tb_ov5640_crop_capture;

   logic        clk = 1'b0;
   logic        s_rst;
   logic        href, vsync;
   logic [7:0]  data;
   logic [11:0] h_start, h_stop, v_start, v_stop;
   logic        swap;
   logic        pix_vld, pix_sof, pix_eol, frame_done, line_err;
   logic [15:0] pix_data;
   logic [11:0] pix_x, pix_y;

   int          n_vec = 0;
   int          n_err = 0;
   int          cnt_vld, cnt_sof, cnt_eol, cnt_fd;
   logic        got_first, first_sof;
   logic [15:0] first_data, last_data;
   logic [11:0] first_x, first_y, eol_x;

   always #5 clk = ~clk;

   ov5640_crop_capture #(.DATA_W(8), .BYTES_PER_PIX(2), .CNT_W(12), .SKIP_FRAMES(2)) dut (
      .ov5640_pclk_i   (clk),
      .s_rst_i         (s_rst),
      .ov5640_href_i   (href),
      .ov5640_vsync_i  (vsync),
      .ov5640_data_i   (data),
      .cfg_h_start_i   (h_start),
      .cfg_h_stop_i    (h_stop),
      .cfg_v_start_i   (v_start),
      .cfg_v_stop_i    (v_stop),
      .cfg_byte_swap_i (swap),
      .pix_vld_o       (pix_vld),
      .pix_data_o      (pix_data),
      .pix_x_o         (pix_x),
      .pix_y_o         (pix_y),
      .pix_sof_o       (pix_sof),
      .pix_eol_o       (pix_eol),
      .frame_done_o    (frame_done),
      .line_err_o      (line_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      cnt_vld = 0; cnt_sof = 0; cnt_eol = 0; cnt_fd = 0;
      got_first = 1'b0; first_sof = 1'b0;
      first_data = '0; last_data = '0; first_x = '0; first_y = '0; eol_x = '0;
   endtask

   // Sample outputs of the previous rising edge, then drive the next input vector.
   task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
      @(negedge clk);
      if (pix_vld) begin
         cnt_vld++;
         if (!got_first) begin
            got_first  = 1'b1;
            first_data = pix_data;
            first_x    = pix_x;
            first_y    = pix_y;
            first_sof  = pix_sof;
         end
         last_data = pix_data;
      end
      if (pix_sof) cnt_sof++;
      if (pix_eol) begin cnt_eol++; eol_x = pix_x; end
      if (frame_done) cnt_fd++;
      vsync = vs; href = hr; data = d;
   endtask

   task automatic vs_pulse();
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_line(input int ln, input int nb);
      for (int i = 0; i < nb; i++) cyc(1'b0, 1'b1, 8'(ln * 16 + i));
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic frame4();
      for (int l = 0; l < 4; l++) send_line(l, 16);
   endtask

   task automatic set_win(input int hs, input int he, input int vs0, input int ve);
      h_start = 12'(hs); h_stop = 12'(he); v_start = 12'(vs0); v_stop = 12'(ve);
   endtask

   initial begin
      s_rst = 1'b1; href = 1'b0; vsync = 1'b0; data = '0; swap = 1'b0;
      set_win(0, 8, 0, 4);
      clr();
      repeat (2) @(negedge clk);
      check("rst_vld", pix_vld, 0);
      check("rst_data", pix_data, 0);
      check("rst_sof", pix_sof, 0);
      check("rst_eol", pix_eol, 0);
      check("rst_fd", frame_done, 0);
      check("rst_err", line_err, 0);
      s_rst = 1'b0;

      // Two skipped frames, third is output in full.
      clr(); vs_pulse(); frame4(); vs_pulse(); frame4();
      check("skip_vld", cnt_vld, 0);
      clr(); vs_pulse(); frame4();
      check("f3_vld", cnt_vld, 32);
      check("f3_sof_first", first_sof, 1);
      check("f3_sof_cnt", cnt_sof, 1);
      check("f3_eol_cnt", cnt_eol, 4);
      check("f3_fd", cnt_fd, 0);
      check("f3_err", line_err, 0);

      // Cropped window h 2..5, v 1..3.
      set_win(2, 5, 1, 3);
      clr(); vs_pulse(); frame4();
      check("crop_fd", cnt_fd, 1);
      check("crop_vld", cnt_vld, 6);
      check("crop_data", first_data, 16'h1415);
      check("crop_x", first_x, 0);
      check("crop_y", first_y, 0);
      check("crop_sof", first_sof, 1);
      check("crop_eol_cnt", cnt_eol, 2);
      check("crop_eol_x", eol_x, 2);
      check("crop_last", last_data, 16'h2829);
      check("crop_err", line_err, 0);

      swap = 1'b1;
      clr(); vs_pulse(); frame4();
      check("swap_data", first_data, 16'h1514);
      check("swap_vld", cnt_vld, 6);

      // Short line of 15 bytes.
      swap = 1'b0; set_win(0, 8, 0, 4);
      clr(); vs_pulse();
      send_line(0, 16); send_line(1, 15); send_line(2, 16); send_line(3, 16);
      check("short_vld", cnt_vld, 31);
      check("short_eol", cnt_eol, 3);
      check("short_err", line_err, 1);

      // Mid-frame config change takes effect one frame later.
      set_win(2, 5, 1, 3);
      clr(); vs_pulse();
      check("err_cleared", line_err, 0);
      send_line(0, 16);
      h_start = 12'd4;
      send_line(1, 16); send_line(2, 16); send_line(3, 16);
      check("mid_vld", cnt_vld, 6);
      check("mid_data", first_data, 16'h1415);
      check("mid_x", first_x, 0);
      clr(); vs_pulse(); frame4();
      check("next_vld", cnt_vld, 2);
      check("next_data", first_data, 16'h1819);
      check("next_x", first_x, 0);
      check("next_eol_x", eol_x, 0);

      // Empty window: nothing emitted, frame_done still pulses.
      set_win(5, 5, 1, 3);
      clr(); vs_pulse(); frame4();
      check("empty_vld", cnt_vld, 0);
      check("empty_err", line_err, 0);
      set_win(0, 8, 0, 4);
      clr(); vs_pulse();
      check("empty_fd", cnt_fd, 1);

      // Reset mid-line while active.
      send_line(0, 16);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'(16 + i));
      check("pre_rst_vld", cnt_vld, 11);
      s_rst = 1'b1;
      @(negedge clk);
      check("mid_rst_vld", pix_vld, 0);
      check("mid_rst_data", pix_data, 0);
      check("mid_rst_x", pix_x, 0);
      check("mid_rst_fd", frame_done, 0);
      check("mid_rst_err", line_err, 0);
      s_rst = 1'b0;
      for (int i = 7; i < 16; i++) cyc(1'b0, 1'b1, 8'(16 + i));
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      clr(); vs_pulse(); frame4(); vs_pulse(); frame4();
      check("reskip_vld", cnt_vld, 0);
      clr(); vs_pulse(); frame4();
      check("reskip_f3_vld", cnt_vld, 32);
      check("reskip_f3_fd", cnt_fd, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ov5640_crop_capture.md
Name: ov5640_crop_capture

Overview:
Parametrised successor to the OV5640 DVP capture/crop stage. Samples the sensor byte bus on the pixel clock and assembles 1..N-byte pixels. Discards the first SKIP_FRAMES frames, then emits pixels inside a runtime-programmable crop window, with window-relative coordinates and frame/line markers. Sits between the SCCB-configured sensor and the frame-buffer writer, in the ov5640_pclk domain.

Parameters:
DATA_W, 8, sensor bus width in bits
BYTES_PER_PIX, 2, bytes per pixel (1..4); PIX_W = DATA_W*BYTES_PER_PIX
CNT_W, 12, width of the coordinate and window counters
SKIP_FRAMES, 10, number of vsync rising edges to discard after reset (0 = output immediately)

Ports:
ov5640_pclk  in  1  pixel clock; all logic is on the rising edge
s_rst  in  1  synchronous, active-high reset
ov5640_href  in  1  line-valid
ov5640_vsync  in  1  frame sync; a rising edge marks the frame boundary
ov5640_data  in  DATA_W  sensor byte
cfg_h_start  in  CNT_W  first pixel column of the crop, inclusive
cfg_h_stop  in  CNT_W  crop column end, exclusive
cfg_v_start  in  CNT_W  first crop line, inclusive
cfg_v_stop  in  CNT_W  crop line end, exclusive
cfg_byte_swap  in  1  0: first byte received -> MSB; 1: first byte received -> LSB
pix_vld  out  1  pixel strobe
pix_data  out  PIX_W  assembled pixel
pix_x  out  CNT_W  column relative to the window (pixel column - h_start)
pix_y  out  CNT_W  line relative to the window (line - v_start)
pix_sof  out  1  with pix_vld: first pixel of the frame's window
pix_eol  out  1  with pix_vld: last pixel of a window line
frame_done  out  1  one-cycle pulse at the frame boundary that ends an output frame
line_err  out  1  sticky error flag; cleared at each frame start

Behaviour:
- Reset (s_rst=1 at a clock edge): all outputs 0, FSM=SKIP, all counters 0, shadow configuration registers 0.
- Edge detection: vs_rise = vsync & ~vsync_d1; href_rise and href_fall are computed the same way from href_d1.
- FSM:
  - SKIP: counts vs_rise. On the SKIP_FRAMES-th vs_rise, go to WAIT_VS; if SKIP_FRAMES=0, go directly from reset to WAIT_VS.
  - WAIT_VS: on vs_rise, latch the cfg_* inputs into shadow registers, clear line_err and the line counter, go to ACTIVE.
  - ACTIVE: on vs_rise, pulse frame_done, re-latch the shadow registers, clear line_err and the line counter, stay in ACTIVE.
- Config is frame-atomic: cfg_* changes mid-frame have no effect until the next vs_rise.
- Byte phase:
  - reset to 0 on href_rise (phase does not free-run across lines);
  - increments on every cycle with href=1; wraps at BYTES_PER_PIX-1.
  - Each byte is placed by phase: MSB-first, or LSB-first when byte_swap=1.
- Pixel complete = href=1 and phase=BYTES_PER_PIX-1. The pixel column counter increments after each complete pixel and resets on href_rise.
- Line counter increments on href_fall.
- Emission, registered, 1-cycle latency after the last byte is sampled, with all outputs updated together:
  - pix_vld=1 iff ACTIVE, col in [h_start,h_stop), line in [v_start,v_stop).
  - pix_sof = (col==h_start && line==v_start).
  - pix_eol = (col==h_stop-1).
  - pix_data, pix_x and pix_y are updated on the same edge as pix_vld and hold their values between strobes.
- Boundary cases:
  - Empty window: if h_stop<=h_start or v_stop<=v_start, no pix_vld for that frame. frame_done still pulses.
  - Short line: on href_fall with phase!=0, the partial pixel is dropped and line_err is set.
  - Over-long window: if a line ends (href_fall) before col reaches h_stop, no pix_eol is produced for that line and line_err is set.
  - vs_rise while href=1: the partial line is abandoned, the counters are cleared and a new frame starts.
  - Counter saturation: col and line saturate at all-ones and never wrap.
  - Coincident events: href_fall and vs_rise in the same cycle means vs_rise wins; the line counter ends at 0.
- Arithmetic: all comparisons are unsigned at CNT_W bits. pix_x and pix_y are CNT_W-bit differences and are non-negative by construction.

Decomposition:
- The FSM state enum, BYTES_PER_PIX-derived widths and PIX_W go in a shared package, ov5640_pkg. This package is shared with the SCCB config block for default window constants (1024x768 sensor; 200/1000/200/680 crop).
- One sub-module: ov5640_byte_pack. It handles phase counting, byte placement and the pixel-complete strobe.
- Window compare, coordinate counters and the FSM live in the top level.

Test Plan:
- SKIP_FRAMES=2, 3 frames of 8x4 pixels, window 0..8 x 0..4 -> no pix_vld in frames 1-2; exactly 32 pix_vld in frame 3; pix_sof on the first of them; 4 pix_eol.
- Window h 2..5, v 1..3 on a 8x4 frame with data = byte index -> 6 pixels emitted; first has pix_x=0, pix_y=0, data=16'h1415 (line 1, col 2); pix_eol at pix_x=2.
- cfg_byte_swap=1, same stimulus -> first pixel data=16'h1514.
- Line with 15 bytes (BYTES_PER_PIX=2) -> 7 pixels on that line, line_err=1, cleared at the next vs_rise.
- cfg_h_start changed mid-frame from 2 to 4 -> current frame still starts at pix_x=0 = col 2; next frame starts at col 4.
- s_rst asserted mid-line in ACTIVE -> next cycle all outputs 0, FSM=SKIP, SKIP_FRAMES count restarts.
